// File: rtl/mul_unit.sv
// Multi-cycle RV32M multiplier: radix-2 shift-add over XLEN cycles, sign fix-up,
// and a four-phase start/done handshake toward the EX-stage controller.
module mul_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      mulctl,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] result,
   output logic            done,
   output logic            busy
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [CW-1:0] LastIter = CW'(XLEN - 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StCalc = 2'd1;
   localparam logic [1:0] StFix  = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   localparam logic [1:0] OpMul = 2'b00;
   localparam logic [1:0] OpMulhu = 2'b11;

   logic [1:0]        state_q, state_d;
   logic [1:0]        ctl_q, ctl_d;
   logic [XLEN-1:0]   mcand_q, mcand_d;
   logic [XLEN-1:0]   mplier_q, mplier_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;

   logic              a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [XLEN-1:0]   addend;
   logic [XLEN:0]     add_sum;
   logic [2*XLEN-1:0] prod_fix;

   // Only operands treated as signed contribute to magnitude and sign; 0x80000000 maps to 2^31.
   always_comb begin
      a_neg = (mulctl != OpMulhu) && a[XLEN-1];
      b_neg = !mulctl[1] && b[XLEN-1];
      a_mag = a_neg ? (~a + 1'b1) : a;
      b_mag = b_neg ? (~b + 1'b1) : b;
   end

   // Carry out of the upper-half add becomes the MSB after the shift.
   always_comb begin
      addend   = mplier_q[0] ? mcand_q : {XLEN{1'b0}};
      add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, addend};
      prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
   end

   always_comb begin
      state_d  = state_q;
      ctl_d    = ctl_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      result_d = result_q;
      done_d   = done_q;
      busy_d   = busy_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               ctl_d    = mulctl;
               mcand_d  = a_mag;
               mplier_d = b_mag;
               neg_d    = a_neg ^ b_neg;
               acc_d    = '0;
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = StCalc;
            end
         end
         StCalc: begin
            acc_d    = {add_sum, acc_q[XLEN-1:1]};
            mplier_d = {1'b0, mplier_q[XLEN-1:1]};
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LastIter) begin
               state_d = StFix;
            end
         end
         StFix: begin
            result_d = (ctl_q == OpMul) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = StDone;
         end
         StDone: begin
            // start is never treated as a new request here, so a held start cannot retrigger.
            if (!start) begin
               done_d  = 1'b0;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            done_d  = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         ctl_q    <= 2'b00;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ctl_q    <= ctl_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         result_q <= result_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign result = result_q;
   assign done   = done_q;
   assign busy   = busy_q;

endmodule
